// File: rtl/sat_mem_bank.sv
// Storage bank with one write port, NUM_RD replicated read ports, RD_LAT 1/2 and a sequential clear engine.
// Writes forward to same-cycle reads; the bank reads as CLEAR_VAL while a clear sweep is running.
module sat_mem_bank #(
    parameter int                WIDTH     = 32,
    parameter int                DEPTH     = 1024,
    parameter int                NUM_RD    = 2,
    parameter int                RD_LAT    = 1,
    parameter logic [WIDTH-1:0]  CLEAR_VAL = '0,
    localparam int               AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    output logic                      wr_ready,
    input  logic [NUM_RD-1:0]         rd_en,
    input  logic [NUM_RD*AW-1:0]      rd_addr,
    output logic [NUM_RD*WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]         rd_valid,
    input  logic                      clear_req,
    output logic                      clear_busy,
    output logic                      clear_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_t;

    localparam logic [AW:0]   DEPTH_X = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            idle;
    logic            wr_acc;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    assign idle       = (state_q == ST_IDLE);
    assign wr_ready   = idle;
    assign clear_busy = (state_q == ST_CLEAR);
    assign clear_done = (state_q == ST_DONE);

    assign wr_acc    = wr_en && idle && ({1'b0, wr_addr} < DEPTH_X);
    assign mem_we    = wr_acc || clear_busy;
    assign mem_waddr = clear_busy ? ptr_q : wr_addr;
    assign mem_wdata = clear_busy ? CLEAR_VAL : wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == LAST) begin
                    state_d = ST_DONE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    ra;
        logic             ra_ok;
        logic [WIDTH-1:0] s1_d, s1_q;
        logic             v1_q;

        assign ra    = rd_addr[p*AW +: AW];
        assign ra_ok = ({1'b0, ra} < DEPTH_X);

        always_ff @(posedge clk) begin
            if (mem_we) begin
                mem[mem_waddr] <= mem_wdata;
            end
        end

        // Any non-idle state means the bank is logically clear, whatever the sweep has reached.
        always_comb begin
            s1_d = mem[ra];
            if (!idle || !ra_ok) begin
                s1_d = CLEAR_VAL;
            end else if (wr_acc && (wr_addr == ra)) begin
                s1_d = wr_data;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_q <= '0;
                v1_q <= 1'b0;
            end else begin
                v1_q <= rd_en[p];
                if (rd_en[p]) begin
                    s1_q <= s1_d;
                end
            end
        end

        if (RD_LAT == 2) begin : g_lat2
            logic [WIDTH-1:0] s2_q;
            logic             v2_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_q <= '0;
                    v2_q <= 1'b0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        s2_q <= s1_q;
                    end
                end
            end

            assign rd_data[p*WIDTH +: WIDTH] = s2_q;
            assign rd_valid[p]               = v2_q;
        end else begin : g_lat1
            assign rd_data[p*WIDTH +: WIDTH] = s1_q;
            assign rd_valid[p]               = v1_q;
        end
    end

endmodule

// File: tb/tb_sat_mem_bank.sv
// Directed bench: two banks (RD_LAT 1 and 2) share all inputs and are checked against hand-computed values.
module tb_sat_mem_bank;

    localparam int          W  = 32;
    localparam int          D  = 2560;
    localparam int          AW = 12;
    localparam logic [31:0] CV = 32'hDEAD_BEEF;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [1:0]    rd_en;
    logic [2*AW-1:0] rd_addr;
    logic          clear_req;

    logic [2*W-1:0] rd_data1, rd_data2;
    logic [1:0]     rd_valid1, rd_valid2;
    logic           wr_ready1, wr_ready2, busy1, busy2, done1, done2;

    int n_cmp = 0;
    int n_err = 0;

    sat_mem_bank #(.WIDTH(W), .DEPTH(D), .NUM_RD(2), .RD_LAT(1), .CLEAR_VAL(CV)) u_lat1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready1), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .clear_req(clear_req), .clear_busy(busy1), .clear_done(done1)
    );

    sat_mem_bank #(.WIDTH(W), .DEPTH(D), .NUM_RD(2), .RD_LAT(2), .CLEAR_VAL(CV)) u_lat2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready2), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2),
        .rd_valid(rd_valid2), .clear_req(clear_req), .clear_busy(busy2), .clear_done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one read on both ports, then check both latencies and the hold behaviour.
    task automatic rd2(input string tag, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [31:0] e0, input logic [31:0] e1);
        rd_en   = 2'b11;
        rd_addr = {a1, a0};
        tick();
        rd_en     = 2'b00;
        wr_en     = 1'b0;
        clear_req = 1'b0;
        chk({tag, "/l1_vld"}, {30'd0, rd_valid1}, 32'd3);
        chk({tag, "/l1_p0"},  rd_data1[31:0],  e0);
        chk({tag, "/l1_p1"},  rd_data1[63:32], e1);
        chk({tag, "/l2_vld_early"}, {30'd0, rd_valid2}, 32'd0);
        tick();
        chk({tag, "/l1_vld_off"}, {30'd0, rd_valid1}, 32'd0);
        chk({tag, "/l1_hold"},    rd_data1[31:0], e0);
        chk({tag, "/l2_vld"}, {30'd0, rd_valid2}, 32'd3);
        chk({tag, "/l2_p0"},  rd_data2[31:0],  e0);
        chk({tag, "/l2_p1"},  rd_data2[63:32], e1);
    endtask

    initial begin
        int n;
        int bad_done;
        int bad_busy;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 2'b00; rd_addr = '0; clear_req = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst/rd_data1", rd_data1[31:0] | rd_data1[63:32], 32'd0);
        chk("rst/rd_data2", rd_data2[31:0] | rd_data2[63:32], 32'd0);
        chk("rst/rd_valid", {28'd0, rd_valid2, rd_valid1}, 32'd0);
        chk("rst/busy_done", {28'd0, busy2, busy1, done2, done1}, 32'd0);
        chk("rst/wr_ready", {30'd0, wr_ready2, wr_ready1}, 32'd3);
        rst = 1'b0;
        tick();

        // Full clear: busy for exactly D cycles, then one done pulse
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = 0; bad_done = 0;
        while (busy1 && n < 5000) begin
            n++;
            if (done1 || done2 || wr_ready1) bad_done++;
            tick();
        end
        chk("clr1/busy_cycles", n, D);
        chk("clr1/done_in_busy", bad_done, 0);
        chk("clr1/done_pulse", {30'd0, done2, done1}, 32'd3);
        tick();
        chk("clr1/done_off", {30'd0, done2, done1}, 32'd0);
        chk("clr1/wr_ready", {30'd0, wr_ready2, wr_ready1}, 32'd3);

        // Every address on both ports reads the clear value
        for (int i = 0; i < D; i++) begin
            rd_en   = 2'b11;
            rd_addr = {AW'(D - 1 - i), AW'(i)};
            tick();
            chk("sweep/l1_p0", rd_data1[31:0],  CV);
            chk("sweep/l1_p1", rd_data1[63:32], CV);
            if (i > 0) begin
                chk("sweep/l2_p0", rd_data2[31:0],  CV);
                chk("sweep/l2_p1", rd_data2[63:32], CV);
            end
        end
        rd_en = 2'b00;
        tick();
        chk("sweep/l2_last", rd_data2[63:32], CV);
        tick();

        // Plain write then read on both ports
        wr_en = 1'b1; wr_addr = 12'd5; wr_data = 32'h1234;
        tick();
        wr_en = 1'b0;
        rd2("w5", 12'd5, 12'd5, 32'h1234, 32'h1234);

        // Write-first forwarding on both ports
        wr_en = 1'b1; wr_addr = 12'd7; wr_data = 32'hA5A5;
        rd2("fwd7", 12'd7, 12'd7, 32'hA5A5, 32'hA5A5);
        rd2("stored7", 12'd7, 12'd5, 32'hA5A5, 32'h1234);

        // Last valid address and out-of-range accesses
        wr_en = 1'b1; wr_addr = 12'(D - 1); wr_data = 32'h00C0_FFEE;
        tick();
        wr_en = 1'b0;
        wr_en = 1'b1; wr_addr = 12'(D + 1); wr_data = 32'h99;
        rd2("oor_fwd", 12'(D + 1), 12'(D - 1), CV, 32'h00C0_FFEE);
        rd2("oor_after", 12'(D + 1), 12'd1, CV, CV);

        // Pre-load addr 3, then clear with a same-cycle write/read of addr 9
        wr_en = 1'b1; wr_addr = 12'd3; wr_data = 32'h55;
        tick();
        clear_req = 1'b1;
        wr_en = 1'b1; wr_addr = 12'd9; wr_data = 32'h77;
        rd_en = 2'b01; rd_addr = {12'd0, 12'd9};
        tick();
        clear_req = 1'b0; wr_en = 1'b0; rd_en = 2'b00;
        chk("clr2/fwd9_l1", rd_data1[31:0], 32'h77);
        n = 0; bad_done = 0;
        while (busy1 && n < 5000) begin
            n++;
            if (done1 || done2) bad_done++;
            if (n == 2) chk("clr2/fwd9_l2", rd_data2[31:0], 32'h77);
            if (n == 500) clear_req = 1'b1;
            if (n == 501) clear_req = 1'b0;
            if (n == 600) begin
                chk("clr2/wr_ready_busy", {30'd0, wr_ready2, wr_ready1}, 32'd0);
                wr_en = 1'b1; wr_addr = 12'd3; wr_data = 32'h55;
            end
            if (n == 601) wr_en = 1'b0;
            if (n == 700) begin
                rd_en = 2'b11; rd_addr = {12'd2000, 12'd7};
            end
            if (n == 701) begin
                rd_en = 2'b00;
                chk("clr2/mid_l1_p0", rd_data1[31:0],  CV);
                chk("clr2/mid_l1_p1", rd_data1[63:32], CV);
            end
            if (n == 702) begin
                chk("clr2/mid_l2_p0", rd_data2[31:0],  CV);
                chk("clr2/mid_l2_p1", rd_data2[63:32], CV);
            end
            tick();
        end
        chk("clr2/busy_cycles", n, D);
        chk("clr2/done_in_busy", bad_done, 0);
        chk("clr2/done_pulse", {30'd0, done2, done1}, 32'd3);
        tick();
        rd2("clr2/after", 12'd3, 12'd9, CV, CV);
        rd2("clr2/after57", 12'd5, 12'd7, CV, CV);

        // Reset in the middle of a sweep
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (100) tick();
        chk("rstmid/busy_before", {30'd0, busy2, busy1}, 32'd3);
        rst = 1'b1;
        #1;
        chk("rstmid/busy", {30'd0, busy2, busy1}, 32'd0);
        chk("rstmid/wr_ready", {30'd0, wr_ready2, wr_ready1}, 32'd3);
        chk("rstmid/done", {30'd0, done2, done1}, 32'd0);
        tick();
        rst = 1'b0;
        bad_done = 0; bad_busy = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (done1 || done2) bad_done++;
            if (busy1 || busy2 || !wr_ready1) bad_busy++;
        end
        chk("rstmid/no_done", bad_done, 0);
        chk("rstmid/idle", bad_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
